// File: rtl/delay_line_pkg.sv
// Shared types and helpers for the delay-line block.
// Mode encoding, default widths and the rounding-down average.
package delay_line_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    MODE_DELAY = 1'b0,
    MODE_ECHO  = 1'b1
  } mode_e;

  // Sum is carried one bit wider than the operands so the
  // shift never loses the carry; callers truncate to width.
  function automatic logic [31:0] avg_u(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32:1];
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Ports: clk, we/waddr/wdata write, re/raddr read, rdata (1-cycle).
module sdp_ram #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/delay_line_ram.sv
// Circular-buffer delay line with optional echo mix.
// Ports: clk, rst_n, en, flush, mode, delay, din -> dout, dout_valid, primed.
module delay_line_ram
  import delay_line_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH    = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     mode,
  input  logic [ADDRESS_WIDTH-1:0] delay,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     dout_valid,
  output logic                     primed
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] fill;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rdata;
  logic          acc;

  logic          valid_q;
  logic [DW-1:0] din_q;
  mode_e         mode_q;
  logic          gate_q;
  logic          bypass_q;

  logic [DW-1:0] delayed;

  assign acc     = en & ~flush;
  assign rd_addr = wr_ptr - delay;

  sdp_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk   (clk),
    .we    (acc),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (acc),
    .raddr (rd_addr),
    .rdata (rdata)
  );

  // gate_q resets high so dout reads 0 before any strobe,
  // hiding the unreset RAM output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      fill     <= '0;
      valid_q  <= 1'b0;
      din_q    <= '0;
      mode_q   <= MODE_DELAY;
      gate_q   <= 1'b1;
      bypass_q <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      fill    <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= en;
      if (en) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fill     <= (fill == '1) ? fill : fill + 1'b1;
        din_q    <= din;
        mode_q   <= mode_e'(mode);
        gate_q   <= (fill < delay);
        bypass_q <= (delay == '0);
      end
    end
  end

  // RAM returns stale data when reading the address being
  // written, so delay 0 takes the registered input instead.
  always_comb begin
    delayed = rdata;
    unique case (1'b1)
      bypass_q: delayed = din_q;
      gate_q:   delayed = '0;
      default:  delayed = rdata;
    endcase
  end

  always_comb begin
    dout = delayed;
    if (mode_q == MODE_ECHO)
      dout = DW'(avg_u(32'(din_q), 32'(delayed)));
  end

  assign dout_valid = valid_q;
  assign primed     = (fill >= delay);

endmodule

// File: tb/tb_delay_line_ram.sv
// Randomised scoreboard bench for delay_line_ram.
// Reference model keeps the sample history since reset/flush.
module tb_delay_line_ram;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int FMAX = 2**AW - 1;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          flush;
  logic          mode;
  logic [AW-1:0] delay;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          primed;

  int n_checks;
  int n_fail;

  int hist[$];
  int expq[$];
  int last_dout;

  delay_line_ram #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .flush      (flush),
    .mode       (mode),
    .delay      (delay),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .primed     (primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Expected output from the sample history: the sample written
  // dly strobes ago, zero if that many have not been written yet.
  function automatic int model_out(input int d, input int m, input int dly);
    int cnt;
    int dl;
    cnt = hist.size();
    if (dly == 0) dl = d;
    else if (cnt < dly) dl = 0;
    else dl = hist[cnt - dly];
    if (m == 1) return (d + dl) / 2;
    return dl;
  endfunction

  function automatic int model_primed(input int dly);
    int f;
    f = (hist.size() > FMAX) ? FMAX : hist.size();
    return (f >= dly) ? 1 : 0;
  endfunction

  task automatic step(input bit e, input bit fl, input bit m,
                      input int dly, input int d);
    @(negedge clk);
    en    = e;
    flush = fl;
    mode  = m;
    delay = AW'(dly);
    din   = DW'(d);
    #1;
    check("primed", int'(primed), model_primed(dly));
    if (fl) begin
      hist.delete();
    end else if (e) begin
      expq.push_back(model_out(d, int'(m), dly));
      hist.push_back(d);
    end
  endtask

  // Monitor: a pushed expectation must appear as a valid output
  // on the following edge; otherwise dout must hold.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (dout_valid) begin
          if (expq.size() == 0) begin
            check("spurious_valid", 1, 0);
          end else begin
            check("dout", int'(dout), expq.pop_front());
          end
          last_dout = int'(dout);
        end else begin
          if (expq.size() != 0) begin
            check("missing_valid", 0, 1);
            void'(expq.pop_front());
          end
          check("dout_hold", int'(dout), last_dout);
        end
      end
    end
  end

  task automatic scenario1();
    int v[5];
    v = '{10, 20, 30, 40, 50};
    foreach (v[i]) step(1, 0, 0, 3, v[i]);
    step(0, 0, 0, 3, 0);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_dout", int'(dout), 0);
    check("rst_valid", int'(dout_valid), 0);
    check("rst_primed", int'(primed), 0);
    hist.delete();
    expq.delete();
    last_dout = 0;
    @(negedge clk);
    en    = 1'b0;
    flush = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    last_dout = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    flush = 1'b0;
    mode  = 1'b0;
    delay = AW'(3);
    din   = '0;
    #1;
    check("init_dout", int'(dout), 0);
    check("init_valid", int'(dout_valid), 0);
    check("init_primed", int'(primed), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    scenario1();

    step(1, 0, 0, 0, 8'h55);
    step(0, 0, 0, 0, 0);

    step(0, 1, 0, 1, 0);
    step(1, 0, 1, 1, 200);
    step(1, 0, 1, 1, 255);
    step(0, 0, 1, 1, 0);

    step(0, 1, 0, 15, 0);
    for (int i = 0; i <= 40; i++) step(1, 0, 0, 15, i);
    step(0, 0, 0, 15, 0);

    step(0, 1, 0, 3, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 3, 60 + i);
    step(1, 1, 0, 3, 99);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 3, 70 + i);

    for (int i = 0; i < 4; i++) step(1, 0, 0, 3, 110 + i);
    mid_reset();
    scenario1();

    begin
      int dly;
      dly = 5;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 15) == 0) dly = $urandom_range(0, FMAX);
        step($urandom_range(0, 3) != 0,
             $urandom_range(0, 60) == 0,
             1'($urandom_range(0, 1)),
             dly,
             $urandom_range(0, 255));
      end
    end

    step(0, 0, 0, 3, 0);
    step(0, 0, 0, 3, 0);
    check("queue_drained", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_line_ram.md
Name: delay_line_ram

Overview:
- Parametrised circular-buffer delay line for the signal-generator path, built around a simple dual-port synchronous RAM.
- Each sample strobe writes one input sample. The block outputs the sample written `delay` strobes earlier, either alone or averaged with the current input (echo mode).
- Sits between the waveform ROM/counter output and the DAC/vbuddy sink. Delay is runtime-programmable up to 2**ADDRESS_WIDTH-1 samples.

Parameters:
- ADDRESS_WIDTH, 9: buffer depth is 2**ADDRESS_WIDTH samples; also the width of `delay`.
- DATA_WIDTH, 8: unsigned sample width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  sample strobe; one sample accepted per cycle with en=1.
- flush  in  1  synchronous clear of pointer and fill count.
- mode  in  1  0 = pure delay, 1 = echo (average of din and delayed sample).
- delay  in  ADDRESS_WIDTH  delay in samples; 0 means bypass.
- din  in  DATA_WIDTH  input sample, sampled when en=1.
- dout  out  DATA_WIDTH  output sample, registered.
- dout_valid  out  1  one-cycle pulse, one cycle after each accepted en.
- primed  out  1  high once at least `delay` samples have been written since reset/flush.

Behaviour:
- Reset (async, rst_n=0):
  - wr_ptr=0, fill=0, dout=0, dout_valid=0, primed=0.
  - RAM contents are not reset; they are undefined and never observed, because the fill gating below hides them.
- Write path: on en=1, RAM[wr_ptr] <= din and wr_ptr <= wr_ptr+1, wrapping mod 2**ADDRESS_WIDTH.
- Read path:
  - On en=1, rd_addr = (wr_ptr - delay) mod 2**ADDRESS_WIDTH is read synchronously.
  - Result is available the next cycle: latency is exactly 1 cycle from en to dout/dout_valid.
- Fill counter:
  - Increments on each en and saturates at 2**ADDRESS_WIDTH-1.
  - delayed sample = 0 if fill < delay (fill evaluated before the increment), else the RAM data.
- delay=0:
  - rd_addr equals wr_ptr, and the RAM returns old data on read-during-write.
  - The block must instead bypass: delayed sample = din of the same strobe (registered).
- mode 0: dout <= delayed sample.
- mode 1: dout <= (din + delayed) >> 1.
  - Sum is DATA_WIDTH+1 bits, truncated after the shift (round down), so no overflow.
  - din and mode are those of the strobe cycle, registered alongside the read.
- en=0: no write, no pointer or fill change, dout holds its value, dout_valid=0.
- primed = (fill >= delay), combinational from registered fill and the current delay.
- Delay changes take effect on the next en. No retiming or interpolation; sample discontinuity is acceptable.
- flush=1:
  - Next cycle: wr_ptr=0, fill=0, dout_valid=0; dout holds.
  - flush takes priority over a simultaneous en; that sample is dropped.
- Reset mid-operation: all registers clear immediately (async). The first strobe after release behaves as after power-up.
- Wrap-around:
  - Subtraction is modular, so rd_addr wraps below 0 correctly.
  - Maximum delay 2**ADDRESS_WIDTH-1 never aliases the address being written.

Decomposition:
- Package delay_line_pkg:
  - mode enum: MODE_DELAY=1'b0, MODE_ECHO=1'b1.
  - Default ADDRESS_WIDTH/DATA_WIDTH localparams.
  - Function `avg_u(a,b)` for the (a+b)>>1 rule.
- Sub-module sdp_ram:
  - Simple dual-port RAM: one write port, one registered read port with rd_en, no reset on the array.
  - Instantiated once; pointer, fill, bypass and mix logic stay in the top.

Test Plan:
- Reset, then delay=3, mode=0, en every cycle with din=10,20,30,40,50 -> dout=0,0,0,10,20 (each 1 cycle after its en); dout_valid high on each of those cycles; primed rises after the 3rd strobe.
- delay=0, mode=0, din=0x55 on one strobe -> next cycle dout=0x55, dout_valid=1 (bypass, not stale RAM).
- mode=1, delay=1, din=200 then 255 -> second output = (255+200)>>1 = 227; first output = (200+0)>>1 = 100.
- ADDRESS_WIDTH=4, delay=15, stream din=0..40 -> dout equals din-15 once fill>=15 (first non-gated output 0 for din=15), correct across pointer wrap at 16 and 32.
- Mid-stream flush asserted together with en and din=99 -> 99 never appears at dout, dout_valid=0 next cycle, dout holds, primed=0, outputs gated to 0 until `delay` new strobes.
- rst_n pulsed low between clock edges during streaming -> dout=0, dout_valid=0, primed=0 immediately; after release, sequence matches the first scenario.
